// File: rtl/nec_tx_pkg.sv
// Shared types, unit durations and frame packing for the NEC IR transmitter.
package nec_tx_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StGap,
    StRepMark,
    StRepSpace,
    StRepStop
  } nec_state_e;

  localparam logic [4:0] LEAD_MARK_U  = 5'd16;
  localparam logic [4:0] LEAD_SPACE_U = 5'd8;
  localparam logic [4:0] BIT_MARK_U   = 5'd1;
  localparam logic [4:0] ZERO_SPACE_U = 5'd1;
  localparam logic [4:0] ONE_SPACE_U  = 5'd3;
  localparam logic [4:0] STOP_U       = 5'd1;
  localparam logic [4:0] REP_SPACE_U  = 5'd4;

  // Bit 0 of the packed word is address[0]; the frame goes out LSB first.
  function automatic logic [31:0] pack_frame(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

  function automatic logic [4:0] state_units(input nec_state_e st, input logic bit_val);
    logic [4:0] units;
    case (st)
      StLeadMark:  units = LEAD_MARK_U;
      StLeadSpace: units = LEAD_SPACE_U;
      StBitMark:   units = BIT_MARK_U;
      StBitSpace:  units = bit_val ? ONE_SPACE_U : ZERO_SPACE_U;
      StStopMark:  units = STOP_U;
      StRepMark:   units = LEAD_MARK_U;
      StRepSpace:  units = REP_SPACE_U;
      StRepStop:   units = STOP_U;
      default:     units = 5'd1;
    endcase
    return units;
  endfunction

  function automatic logic is_mark(input nec_state_e st);
    return st inside {StLeadMark, StBitMark, StStopMark, StRepMark, StRepStop};
  endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// Free-running carrier counter; restart forces a fresh high phase at the start of a mark.
module nec_carrier_gen #(
  parameter int unsigned CLKS_PER_CARRIER = 1316,
  parameter int unsigned CARRIER_HIGH     = 439
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic carrier
);
  localparam int unsigned CW = $clog2(CLKS_PER_CARRIER);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || cnt_q == CW'(CLKS_PER_CARRIER - 1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carrier = cnt_q < CW'(CARRIER_HIGH);

endmodule

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: frames address/command, emits repeat codes while hold is high,
// and drives a carrier-modulated LED output.
module nec_ir_tx
  import nec_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_UNIT    = 28125,
  parameter int unsigned CLKS_PER_CARRIER = 1316,
  parameter int unsigned CARRIER_HIGH     = 439,
  parameter int unsigned FRAME_UNITS      = 192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  output logic       ready,
  input  logic [7:0] address,
  input  logic [7:0] command,
  input  logic       hold,
  output logic       ir_out,
  output logic       envelope,
  output logic       busy
);
  localparam int unsigned UW = $clog2(CLKS_PER_UNIT);
  localparam int unsigned FW = $clog2(FRAME_UNITS);

  nec_state_e    state_q, state_d;
  logic [UW-1:0] unit_cnt_q, unit_cnt_d;
  logic [4:0]    units_q, units_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [31:0]   shift_q, shift_d;
  logic          tick, state_done, gap_done, accept, restart, carrier;

  assign tick       = unit_cnt_q == UW'(CLKS_PER_UNIT - 1);
  assign state_done = tick && (units_q == (state_units(state_q, shift_q[0]) - 5'd1));
  assign gap_done   = (state_q == StGap) && tick && (frame_cnt_q == FW'(FRAME_UNITS - 1));
  // The last gap cycle already offers ready so a held valid gives frames exactly one period apart.
  assign ready      = (state_q == StIdle) || (gap_done && !hold);
  assign accept     = valid && ready;

  always_comb begin
    state_d     = state_q;
    unit_cnt_d  = tick ? '0 : unit_cnt_q + 1'b1;
    units_d     = (tick && state_q != StGap) ? units_q + 5'd1 : units_q;
    frame_cnt_d = tick ? frame_cnt_q + 1'b1 : frame_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;

    unique case (state_q)
      StIdle:      state_d = StIdle;
      StLeadMark:  if (state_done) state_d = StLeadSpace;
      StLeadSpace: if (state_done) state_d = StBitMark;
      StBitMark:   if (state_done) state_d = StBitSpace;
      StBitSpace: begin
        if (state_done) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 5'd1;
          state_d   = (bit_idx_q == 5'd31) ? StStopMark : StBitMark;
        end
      end
      StStopMark:  if (state_done) state_d = StGap;
      StGap:       if (gap_done) state_d = hold ? StRepMark : StIdle;
      StRepMark:   if (state_done) state_d = StRepSpace;
      StRepSpace:  if (state_done) state_d = StRepStop;
      StRepStop:   if (state_done) state_d = StGap;
      default:     state_d = StIdle;
    endcase

    if (accept) begin
      state_d   = StLeadMark;
      shift_d   = pack_frame(address, command);
      bit_idx_d = '0;
    end

    if (state_d != state_q || state_q == StIdle) begin
      unit_cnt_d = '0;
      units_d    = '0;
    end

    if (accept || state_d == StIdle || (state_d == StRepMark && state_q != StRepMark)) begin
      frame_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      unit_cnt_q  <= '0;
      units_q     <= '0;
      frame_cnt_q <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      unit_cnt_q  <= unit_cnt_d;
      units_q     <= units_d;
      frame_cnt_q <= frame_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
    end
  end

  assign restart = (state_d != state_q) && is_mark(state_d);

  nec_carrier_gen #(
    .CLKS_PER_CARRIER(CLKS_PER_CARRIER),
    .CARRIER_HIGH    (CARRIER_HIGH)
  ) u_carrier (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .carrier(carrier)
  );

  assign envelope = is_mark(state_q);
  assign ir_out   = envelope && carrier;
  assign busy     = state_q != StIdle;

endmodule
